uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader_if.sv | 28 ++
 rtl/uart_boot_loader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port of the UART boot loader.
//   io_o_mem_valid  word write request (loader -> memory)
//   io_o_mem_addr   word-aligned byte address
//   io_o_mem_wdata  little-endian write data
//   io_i_mem_ready  memory accepts when valid && ready on a clock edge
// master: the loader side. slave: the memory side.
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              io_o_mem_valid;
    logic [ADDR_W-1:0] io_o_mem_addr;
    logic [31:0]       io_o_mem_wdata;
    logic              io_i_mem_ready;

    modport master (
        output io_o_mem_valid,
        output io_o_mem_addr,
        output io_o_mem_wdata,
        input  io_i_mem_ready
    );

    modport slave (
        input  io_o_mem_valid,
        input  io_o_mem_addr,
        input  io_o_mem_wdata,
        output io_i_mem_ready
    );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an image over an 8N1 UART line and writes it as 32-bit words
// into instruction memory, holding the core (busy) while loading.
// Stream: length N (16 bit, low byte first), N x 4 data bytes (little-endian words),
// then one XOR checksum byte when BOOT_CHECKSUM_EN is defined.
// Ports:
//   clock           single rising-edge clock
//   reset           asynchronous, active-high reset
//   io_i_boot       boot-mode request (level)
//   io_i_rx         UART receive line, idle high
//   mem             memory write port (uart_boot_loader_if.master)
//   io_o_busy       loader active, core held
//   io_o_done       image loaded; sticky until boot drops
//   io_o_err        sticky error (framing, overrun, checksum)
// Optional feature macro: BOOT_CHECKSUM_EN (adds the CHK state and trailing checksum byte).
module uart_boot_loader #(
    parameter int unsigned CLK_PER_BIT = 104,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_i_boot,
    input  logic               io_i_rx,
    uart_boot_loader_if.master mem,
    output logic               io_o_busy,
    output logic               io_o_done,
    output logic               io_o_err
);

    localparam int unsigned CntW = $clog2(CLK_PER_BIT);
    localparam logic [CntW-1:0] FullBit = CntW'(CLK_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StWrite,
`ifdef BOOT_CHECKSUM_EN
        StChk,
`endif
        StDone
    } state_e;

`ifdef BOOT_CHECKSUM_EN
    localparam state_e StEnd = StChk;
`else
    localparam state_e StEnd = StDone;
`endif

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_byte_valid, rx_frame_err;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_byte_valid = 1'b0;
        rx_frame_err  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfBit) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // a start bit that is high again at mid-bit was a glitch
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == FullBit) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == FullBit) begin
                    rx_state_d    = RxIdle;
                    rx_byte_valid = rx_sync_q;
                    rx_frame_err  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- holding register ----------------
    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       consume, overrun;

    // Every state but WRITE takes the byte; IDLE and DONE simply throw it away.
    assign consume = hold_full_q && (state_q != StWrite);
    assign overrun = rx_byte_valid && hold_full_q && !consume;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (rx_byte_valid && !overrun) begin
            hold_d      = rx_shift_q;
            hold_full_d = 1'b1;
        end
    end

    // ---------------- loader FSM ----------------
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
    logic              csum_bad;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        err_d      = err_q;
        csum_bad   = 1'b0;
        case (state_q)
            StIdle: begin
                if (io_i_boot) begin
                    state_d = StLen0;
                    addr_d  = '0;
                    count_d = '0;
                    csum_d  = '0;
                    err_d   = 1'b0;
                end
            end
            StLen0: begin
                if (!io_i_boot) begin
                    state_d = StIdle;
                end else if (hold_full_q) begin
                    count_d[7:0] = hold_q;
                    csum_d       = csum_q ^ hold_q;
                    state_d      = StLen1;
                end
            end
            StLen1: begin
                if (!io_i_boot) begin
                    state_d = StIdle;
                end else if (hold_full_q) begin
                    count_d[15:8] = hold_q;
                    csum_d        = csum_q ^ hold_q;
                    byte_idx_d    = '0;
                    state_d       = ({hold_q, count_q[7:0]} == 16'h0) ? StEnd : StData;
                end
            end
            StData: begin
                if (!io_i_boot) begin
                    state_d = StIdle;
                end else if (hold_full_q) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = hold_q;
                    csum_d     = csum_q ^ hold_q;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // an accepted write is never abandoned, even if boot drops
                if (mem.io_i_mem_ready) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = count_q - 1'b1;
                    if (!io_i_boot) begin
                        state_d = StIdle;
                    end else if (count_q == 16'd1) begin
                        state_d = StEnd;
                    end else begin
                        state_d = StData;
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            StChk: begin
                if (!io_i_boot) begin
                    state_d = StIdle;
                end else if (hold_full_q) begin
                    csum_bad = (hold_q != csum_q);
                    state_d  = StDone;
                end
            end
`endif
            StDone: begin
                if (!io_i_boot) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rx_frame_err || overrun || csum_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            state_q     <= StIdle;
            addr_q      <= '0;
            count_q     <= '0;
            wdata_q     <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            rx_meta_q   <= io_i_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            wdata_q     <= wdata_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            err_q       <= err_d;
        end
    end

    assign mem.io_o_mem_valid = (state_q == StWrite);
    assign mem.io_o_mem_addr  = addr_q;
    assign mem.io_o_mem_wdata = wdata_q;
    assign io_o_busy          = (state_q != StIdle) && (state_q != StDone);
    assign io_o_done          = (state_q == StDone);
    assign io_o_err           = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader (CLK_PER_BIT=8, ADDR_W=16).
// Expected memory writes are queued by each scenario and checked by a write monitor.
module tb_uart_boot_loader;
    localparam int unsigned CPB = 8;
    localparam int unsigned AW  = 16;

    logic clock = 1'b0;
    logic reset;
    logic boot;
    logic rx;
    logic busy, done, err;

    uart_boot_loader_if #(.ADDR_W(AW)) mem_if ();

    uart_boot_loader #(.CLK_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_i_boot (boot),
        .io_i_rx   (rx),
        .mem       (mem_if),
        .io_o_busy (busy),
        .io_o_done (done),
        .io_o_err  (err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int write_cnt = 0;
    logic [47:0] exp_q [$];

    // Scoreboard: every accepted write must match the next queued {addr, data}.
    always @(negedge clock) begin
        if (!reset && mem_if.io_o_mem_valid && mem_if.io_i_mem_ready) begin
            write_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got addr=%h data=%h want none",
                         mem_if.io_o_mem_addr, mem_if.io_o_mem_wdata);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({mem_if.io_o_mem_addr, mem_if.io_o_mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL write_data got addr=%h data=%h want addr=%h data=%h",
                             mem_if.io_o_mem_addr, mem_if.io_o_mem_wdata, e[47:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Called and returns at posedge+1.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        rx = 1'b0;
        repeat (CPB) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
        rx = stop;
        repeat (CPB) @(posedge clock);
        #1;
        rx = 1'b1;
        if (gap > 0) begin
            repeat (gap) @(posedge clock);
            #1;
        end
    endtask

    task automatic end_session();
        boot = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        boot  = 1'b0;
        rx    = 1'b1;
        mem_if.io_i_mem_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (mem_if.io_o_mem_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", mem_if.io_o_mem_valid); end
        total++; if (mem_if.io_o_mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_if.io_o_mem_addr); end
        total++; if (mem_if.io_o_mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_if.io_o_mem_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_single_write();
        logic [7:0] s [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic [7:0] cs = 8'h00;
        int w0 = write_cnt;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        exp_q.push_back({16'h0000, 32'hDEADBEEF});
        foreach (s[i]) begin
            send_byte(s[i], 1'b1, CPB);
            cs ^= s[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs, 1'b1, CPB);
`endif
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%b want=0", busy); end
        total++; if (write_cnt - w0 !== 1) begin bad++; $display("FAIL single_writes got=%0d want=1", write_cnt - w0); end
        @(posedge clock);
        #1;
        end_session();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_clear got=%b want=0", done); end
    endtask

    task automatic test_stall();
        logic [7:0] s [6] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] t [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        logic [7:0] cs = 8'h00;
        int w0 = write_cnt;
        mem_if.io_i_mem_ready = 1'b0;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back({16'h0000, 32'h44332211});
        exp_q.push_back({16'h0004, 32'h88776655});
        foreach (s[i]) begin
            send_byte(s[i], 1'b1, CPB);
            cs ^= s[i];
        end
        for (int i = 0; i < 100 && mem_if.io_o_mem_valid !== 1'b1; i++) @(negedge clock);
        total++; if (mem_if.io_o_mem_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", mem_if.io_o_mem_valid); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            total++;
            if ({mem_if.io_o_mem_valid, mem_if.io_o_mem_addr, mem_if.io_o_mem_wdata} !==
                {1'b1, 16'h0000, 32'h44332211}) begin
                bad++;
                $display("FAIL stall_stable cycle=%0d got v=%b a=%h d=%h want v=1 a=0000 d=44332211",
                         c, mem_if.io_o_mem_valid, mem_if.io_o_mem_addr, mem_if.io_o_mem_wdata);
            end
        end
        total++; if (write_cnt !== w0) begin bad++; $display("FAIL stall_no_accept got=%0d want=%0d", write_cnt, w0); end
        @(posedge clock);
        #1;
        mem_if.io_i_mem_ready = 1'b1;
        foreach (t[i]) begin
            send_byte(t[i], 1'b1, CPB);
            cs ^= t[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs, 1'b1, CPB);
`endif
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", done); end
        total++; if (write_cnt - w0 !== 2) begin bad++; $display("FAIL stall_writes got=%0d want=2", write_cnt - w0); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL stall_err got=%b want=0", err); end
        @(posedge clock);
        #1;
        end_session();
    endtask

    task automatic test_framing();
        logic [7:0] s [6] = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] g [6] = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] cs = 8'h00;
        int w0 = write_cnt;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back({16'h0000, 32'h04030201});
        for (int i = 0; i < 2; i++) begin
            send_byte(s[i], 1'b1, CPB);
            cs ^= s[i];
        end
        send_byte(8'hAA, 1'b0, CPB);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL framing_err got=%b want=1", err); end
        for (int i = 2; i < 6; i++) begin
            send_byte(s[i], 1'b1, CPB);
            cs ^= s[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs, 1'b1, CPB);
`endif
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL framing_done got=%b want=1", done); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL framing_err_sticky got=%b want=1", err); end
        total++; if (write_cnt - w0 !== 1) begin bad++; $display("FAIL framing_writes got=%0d want=1", write_cnt - w0); end
        @(posedge clock);
        #1;
        end_session();

        // New session clears err; a one-cycle low glitch must not become a byte.
        w0 = write_cnt;
        cs = 8'h00;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL glitch_err_clear got=%b want=0", err); end
        rx = 1'b0;
        @(posedge clock);
        #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clock);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL glitch_err got=%b want=0", err); end
        exp_q.push_back({16'h0000, 32'h44332211});
        foreach (g[i]) begin
            send_byte(g[i], 1'b1, CPB);
            cs ^= g[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs, 1'b1, CPB);
`endif
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL glitch_done got=%b want=1", done); end
        total++; if (write_cnt - w0 !== 1) begin bad++; $display("FAIL glitch_writes got=%0d want=1", write_cnt - w0); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL glitch_err_end got=%b want=0", err); end
        @(posedge clock);
        #1;
        end_session();
    endtask

    task automatic test_abort();
        int w0 = write_cnt;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        send_byte(8'h01, 1'b1, CPB);
        send_byte(8'h00, 1'b1, CPB);
        send_byte(8'hAA, 1'b1, CPB);
        send_byte(8'hBB, 1'b1, CPB);
        fork
            send_byte(8'hCC, 1'b1, CPB);
            begin
                repeat (4 * CPB) @(posedge clock);
                #1;
                boot = 1'b0;
                @(posedge clock);
                #1;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_next got=%b want=0", busy); end
            end
        join
        send_byte(8'hDD, 1'b1, CPB);
        repeat (10) @(posedge clock);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err got=%b want=0", err); end
        total++; if (write_cnt !== w0) begin bad++; $display("FAIL abort_writes got=%0d want=%0d", write_cnt, w0); end
    endtask

    task automatic test_checksum();
        logic [7:0] s [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic [7:0] cs = 8'h00;
        int w0 = write_cnt;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back({16'h0000, 32'hDEADBEEF});
        foreach (s[i]) begin
            send_byte(s[i], 1'b1, CPB);
            cs ^= s[i];
        end
        send_byte(cs ^ 8'hFF, 1'b1, CPB);
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL csum_done got=%b want=1", done); end
`ifdef BOOT_CHECKSUM_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL csum_err got=%b want=1", err); end
`else
        total++; if (err !== 1'b0) begin bad++; $display("FAIL csum_extra_err got=%b want=0", err); end
`endif
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL csum_busy got=%b want=0", busy); end
        total++; if (write_cnt - w0 !== 1) begin bad++; $display("FAIL csum_writes got=%0d want=1", write_cnt - w0); end
        @(posedge clock);
        #1;
        end_session();
    endtask

    task automatic test_back_to_back();
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        int w0 = write_cnt;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        cs = 8'h03;
        for (int w = 0; w < 3; w++) begin
            logic [31:0] word;
            for (int k = 0; k < 4; k++) word[8*k +: 8] = 8'(16 * w + 3 * k + 1);
            exp_q.push_back({16'(4 * w), word});
        end
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(16 * w + 3 * k + 1);
                send_byte(b, 1'b1, 0);
                cs ^= b;
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs, 1'b1, 0);
`endif
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
        total++; if (write_cnt - w0 !== 3) begin bad++; $display("FAIL b2b_writes got=%0d want=3", write_cnt - w0); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", err); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_queue got=%0d want=0", exp_q.size()); end
        @(posedge clock);
        #1;
        end_session();
    endtask

    task automatic test_async_reset();
        int w0 = write_cnt;
        mem_if.io_i_mem_ready = 1'b0;
        boot = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        send_byte(8'h01, 1'b1, CPB);
        send_byte(8'h00, 1'b1, CPB);
        for (int i = 0; i < 4; i++) send_byte(8'h5A, 1'b1, CPB);
        for (int i = 0; i < 100 && mem_if.io_o_mem_valid !== 1'b1; i++) @(negedge clock);
        total++; if (mem_if.io_o_mem_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%b want=1", mem_if.io_o_mem_valid); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (mem_if.io_o_mem_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", mem_if.io_o_mem_valid); end
        total++; if (mem_if.io_o_mem_addr !== 16'h0) begin bad++; $display("FAIL areset_addr got=%h want=0", mem_if.io_o_mem_addr); end
        total++; if (mem_if.io_o_mem_wdata !== 32'h0) begin bad++; $display("FAIL areset_wdata got=%h want=0", mem_if.io_o_mem_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done got=%b want=0", done); end
        @(posedge clock);
        #1;
        boot = 1'b0;
        mem_if.io_i_mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        total++; if (write_cnt !== w0) begin bad++; $display("FAIL areset_writes got=%0d want=%0d", write_cnt, w0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_idle got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall();
        test_framing();
        test_abort();
        test_checksum();
        test_back_to_back();
        test_async_reset();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
